regfile_mp_sb: RTL and testbench

// - Parametrised multi-port integer register file with a per-register busy scoreboard.
// - Generalises the fixed 2-write/4-read bank to NWR write ports, NRD read ports and NISS issue ports.
// - Tracks in-flight destinations and reports per-port read-busy and issue-ready.
// - Flags same-cycle WAW write collisions in a sticky error bit.
// - Sits between the dual-issue decode/issue stage and the writeback stage.

---
 rtl/regfile_mp_sb.sv | 147 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a per-register busy
// scoreboard. NWR writeback ports, NRD combinational read ports, NISS issue
// ports that reserve destination registers. Register 0 is hardwired to zero.
// Optional macro RF_BYPASS_EN: same-cycle writeback data/busy-clear is
// forwarded to the read ports and to the issue-ready check.
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 4,
    parameter int NWR   = 2,
    parameter int NISS  = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic [NISS-1:0]      iss_valid,
    input  logic [NISS*AW-1:0]   iss_rd,
    output logic [NISS-1:0]      iss_ready,
    output logic                 waw_err
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             waw_err_q;
    logic             waw_err_d;

    // Per-register view of this cycle's writebacks after WAW resolution
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic             waw_now;
    logic [NREGS-1:0] eff_busy;

    // Unpacked address views of the flat port buses
    logic [AW-1:0] ra [NRD];
    logic [AW-1:0] wa [NWR];
    logic [AW-1:0] ia [NISS];

    // Split the flat address buses into per-port addresses
    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) ra[k] = rd_addr[k*AW +: AW];
        for (int unsigned j = 0; j < NWR; j++) wa[j] = wr_addr[j*AW +: AW];
        for (int unsigned i = 0; i < NISS; i++) ia[i] = iss_rd[i*AW +: AW];
    end

    // Resolve writebacks per register; ascending scan lets the highest port win
    always_comb begin
        wr_hit  = '0;
        waw_now = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) wr_val[r] = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] != '0)) begin
                if (wr_hit[wa[j]]) waw_now = 1'b1;
                wr_hit[wa[j]] = 1'b1;
                wr_val[wa[j]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Busy as seen by readers and the issue check
    always_comb begin
`ifdef RF_BYPASS_EN
        eff_busy = busy_q & ~wr_hit;
`else
        eff_busy = busy_q;
`endif
        eff_busy[0] = 1'b0;
    end

    // Issue acceptance: blocked by a busy destination or a lower-port claim
    always_comb begin
        iss_ready = '1;
        for (int unsigned i = 0; i < NISS; i++) begin
            if ((ia[i] != '0) && eff_busy[ia[i]]) iss_ready[i] = 1'b0;
            for (int unsigned p = 0; p < i; p++) begin
                if (iss_valid[p] && (ia[p] == ia[i]) && (ia[i] != '0))
                    iss_ready[i] = 1'b0;
            end
        end
    end

    // Combinational read ports
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (ra[k] != '0) begin
                rd_data[k*XLEN +: XLEN] = regs_q[ra[k]];
`ifdef RF_BYPASS_EN
                if (wr_hit[ra[k]]) rd_data[k*XLEN +: XLEN] = wr_val[ra[k]];
`endif
                rd_busy[k] = eff_busy[ra[k]];
            end
        end
    end

    // Next state: writeback clears busy first so a same-cycle issue set wins
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q & ~wr_hit;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) regs_d[r] = wr_val[r];
        end
        for (int unsigned i = 0; i < NISS; i++) begin
            if (iss_valid[i] && iss_ready[i] && (ia[i] != '0))
                busy_d[ia[i]] = 1'b1;
        end
        busy_d[0] = 1'b0;
        waw_err_d = waw_err_q | waw_now;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
            busy_q    <= '0;
            waw_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
            busy_q    <= busy_d;
            waw_err_q <= waw_err_d;
        end
    end

    assign waw_err = waw_err_q;

`ifndef SYNTHESIS
    // Zero-register invariants; writes to non-busy registers are legal
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (regs_q[0] == '0);
            assert (!busy_q[0]);
            for (int unsigned k = 0; k < NRD; k++) begin
                if (ra[k] == '0) assert (rd_data[k*XLEN +: XLEN] == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios followed by random
// traffic, compared against an array-based reference model of the register
// file and its busy scoreboard. Honours RF_BYPASS_EN if defined.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int NISS  = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NISS-1:0]     iss_valid;
    logic [NISS*AW-1:0]  iss_rd;
    logic [NISS-1:0]     iss_ready;
    logic                waw_err;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .NISS(NISS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // Reference model state
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_waw;

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_waw = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int waddr(int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    function automatic int iaddr(int i);
        return int'(iss_rd[i*AW +: AW]);
    endfunction

    // Is register r written this cycle, and with which value (last port wins)
    function automatic bit written(int r);
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && r != 0 && waddr(j) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] winner(int r);
        logic [XLEN-1:0] v = '0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && r != 0 && waddr(j) == r) v = wr_data[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(int r);
        if (r == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (written(r)) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int r);
        if (r == 0) return '0;
`ifdef RF_BYPASS_EN
        if (written(r)) return winner(r);
`endif
        return m_regs[r];
    endfunction

    function automatic bit exp_ready(int i);
        int r = iaddr(i);
        if (r != 0 && exp_busy(r)) return 1'b0;
        for (int p = 0; p < i; p++)
            if (iss_valid[p] && r != 0 && iaddr(p) == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string ctx);
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            chk($sformatf("%s.rd_data%0d", ctx, k), rd_data[k*XLEN +: XLEN], exp_data(a));
            chk($sformatf("%s.rd_busy%0d", ctx, k), 32'(rd_busy[k]), 32'(exp_busy(a)));
        end
        for (int i = 0; i < NISS; i++)
            chk($sformatf("%s.iss_ready%0d", ctx, i), 32'(iss_ready[i]), 32'(exp_ready(i)));
        chk($sformatf("%s.waw_err", ctx), 32'(waw_err), 32'(m_waw));
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs
    task automatic tick();
        logic [XLEN-1:0] n_regs [NREGS];
        bit              n_busy [NREGS];
        bit              seen   [NREGS];
        bit              n_waw = m_waw;
        bit              acc    [NISS];
        for (int r = 0; r < NREGS; r++) begin
            n_regs[r] = m_regs[r];
            n_busy[r] = m_busy[r];
            seen[r]   = 1'b0;
        end
        for (int i = 0; i < NISS; i++) acc[i] = iss_valid[i] && exp_ready(i);
        for (int j = 0; j < NWR; j++) begin
            int a = waddr(j);
            if (wr_en[j] && a != 0) begin
                if (seen[a]) n_waw = 1'b1;
                seen[a]   = 1'b1;
                n_regs[a] = wr_data[j*XLEN +: XLEN];
                n_busy[a] = 1'b0;
            end
        end
        for (int i = 0; i < NISS; i++)
            if (acc[i] && iaddr(i) != 0) n_busy[iaddr(i)] = 1'b1;
        @(posedge clk);
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = n_regs[r];
            m_busy[r] = n_busy[r];
        end
        m_waw = n_waw;
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_valid = '0; iss_rd = '0;
    endtask

    task automatic settle(input string ctx);
        #1;
        check_outputs(ctx);
    endtask

    initial begin
        idle();
        model_reset();
        rd_addr = {5'd7, 5'd31, 5'd0, 5'd5};
        #12;
        check_outputs("reset");
        chk("reset.rd_data_all", 32'(rd_data == '0), 32'd1);
        chk("reset.rd_busy", 32'(rd_busy), 32'h0);
        chk("reset.iss_ready", 32'(iss_ready), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;

        // Issue rd=3, then observe busy and write it back
        idle(); iss_valid[0] = 1'b1; iss_rd[0 +: AW] = 5'd3;
        settle("iss3"); tick();
        idle(); iss_rd[0 +: AW] = 5'd3; rd_addr[0 +: AW] = 5'd3;
        settle("busy3");
        chk("busy3.rd_busy0", 32'(rd_busy[0]), 32'd1);
        chk("busy3.iss_ready0", 32'(iss_ready[0]), 32'd0);
        wr_en[0] = 1'b1; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 32'hDEADBEEF;
        settle("wb3"); tick();
        idle(); rd_addr[0 +: AW] = 5'd3;
        settle("after_wb3");
        chk("after_wb3.data", rd_data[0 +: XLEN], 32'hDEADBEEF);
        chk("after_wb3.busy", 32'(rd_busy[0]), 32'd0);

        // WAW collision on reg 9
        idle(); wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11};
        settle("waw9"); tick();
        idle(); rd_addr[0 +: AW] = 5'd9;
        settle("after_waw9");
        chk("after_waw9.data", rd_data[0 +: XLEN], 32'h22);
        chk("after_waw9.err", 32'(waw_err), 32'd1);
        tick(); tick(); tick();
        settle("waw_held");
        chk("waw_held.err", 32'(waw_err), 32'd1);

        // Both issue ports claim rd=4; issue to rd=0
        idle(); iss_valid = 2'b11; iss_rd = {5'd4, 5'd4};
        settle("iss4x2");
        chk("iss4x2.ready", 32'(iss_ready), 32'h1);
        tick();
        idle(); rd_addr[0 +: AW] = 5'd4;
        settle("busy4");
        chk("busy4.rd_busy0", 32'(rd_busy[0]), 32'd1);
        idle(); iss_valid[0] = 1'b1; iss_rd[0 +: AW] = 5'd0;
        settle("iss0");
        chk("iss0.ready", 32'(iss_ready[0]), 32'd1);
        tick();
        idle(); rd_addr[0 +: AW] = 5'd0;
        settle("busy0");
        chk("busy0.rd_busy0", 32'(rd_busy[0]), 32'd0);

        // Writeback and issue to rd=6 together: set wins
        idle(); wr_en[0] = 1'b1; wr_addr[0 +: AW] = 5'd6; wr_data[0 +: XLEN] = 32'h66;
        iss_valid[0] = 1'b1; iss_rd[0 +: AW] = 5'd6;
        settle("wbiss6"); tick();
        idle(); rd_addr[0 +: AW] = 5'd6;
        settle("after6");
        chk("after6.data", rd_data[0 +: XLEN], 32'h66);
        chk("after6.busy", 32'(rd_busy[0]), 32'd1);

        // Same-cycle read of a register being written
        idle(); wr_en[0] = 1'b1; wr_addr[0 +: AW] = 5'd12; wr_data[0 +: XLEN] = 32'hA5A5A5A5;
        rd_addr[0 +: AW] = 5'd12;
        settle("byp12");
`ifdef RF_BYPASS_EN
        chk("byp12.data", rd_data[0 +: XLEN], 32'hA5A5A5A5);
`else
        chk("byp12.data", rd_data[0 +: XLEN], 32'h0);
`endif
        tick();

        // Random traffic, addresses biased low to provoke conflicts
        for (int n = 0; n < 300; n++) begin
            idle();
            for (int k = 0; k < NRD; k++)
                rd_addr[k*AW +: AW] = AW'(($urandom % 4 == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7));
            for (int j = 0; j < NWR; j++) begin
                wr_en[j] = 1'($urandom % 2);
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[j*XLEN +: XLEN] = XLEN'($urandom);
            end
            for (int i = 0; i < NISS; i++) begin
                iss_valid[i] = 1'($urandom % 2);
                iss_rd[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            settle($sformatf("rnd%0d", n));
            tick();
        end

        // Mid-stream asynchronous reset with busy bits outstanding
        idle(); iss_valid = 2'b11; iss_rd = {5'd21, 5'd20};
        settle("pre_rst"); tick();
        idle(); rd_addr[0 +: AW] = 5'd20;
        #1;
        chk("pre_rst.busy20", 32'(rd_busy[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int g = 0; g < NREGS / NRD; g++) begin
            for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(g*NRD + k);
            #1;
            check_outputs($sformatf("rst_mid%0d", g));
            chk($sformatf("rst_mid%0d.data_zero", g), 32'(rd_data == '0), 32'd1);
            chk($sformatf("rst_mid%0d.busy_zero", g), 32'(rd_busy), 32'h0);
        end
        chk("rst_mid.waw", 32'(waw_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); iss_rd = {5'd21, 5'd20};
        settle("post_rst");
        chk("post_rst.ready", 32'(iss_ready), 32'h3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
